// File: rtl/dmem_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dmem_line_responder                                            |
// | Fixed-latency 256-bit line memory responder behind the dcache.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dmem_line_responder #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mem_enable_i,
  input  logic         mem_write_i,
  input  logic [31:0]  mem_addr_i,
  input  logic [255:0] mem_data_i,
  output logic         mem_ack_o,
  output logic [255:0] mem_data_o,
  output logic         busy_o
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_write;
  logic [255:0]     r_wdata;
  logic [255:0]     r_mem [DEPTH];

  logic             w_commit;
  logic             w_unused_addr_bits;

  assign w_commit = (r_state == S_WAIT) && (r_cnt == '0);
  assign busy_o   = (r_state != S_IDLE);

  // Offset bits and index bits above the array size are don't-care.
  assign w_unused_addr_bits = ^{mem_addr_i[31:IDX_W+5], mem_addr_i[4:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      mem_ack_o  <= 1'b0;
      mem_data_o <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          mem_ack_o <= 1'b0;
          if (mem_enable_i) begin
            r_idx   <= mem_addr_i[IDX_W+4:5];
            r_write <= mem_write_i;
            r_wdata <= mem_data_i;
            r_cnt   <= c_cnt_init;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            mem_ack_o <= 1'b1;
            if (!r_write) begin
              mem_data_o <= r_mem[r_idx];
            end
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          mem_ack_o <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          mem_ack_o <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Array is deliberately outside the reset domain; a reset only aborts the commit.
  always_ff @(posedge clk_i) begin
    if (w_commit && r_write && !rst_i) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_line_responder.sv
`default_nettype none
// Bench for dmem_line_responder: directed protocol cases plus randomized
// requests checked against a line-array reference model.
module tb_dmem_line_responder;

  localparam int LAT     = 10;
  localparam int DEPTH   = 512;
  localparam int IDX_W   = 9;
  localparam int LAT_B   = 1;
  localparam int DEPTH_B = 16;
  localparam int IDX_W_B = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, we;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic         ack;
  logic [255:0] rdata;
  logic         busy;

  logic         en_b, we_b;
  logic [31:0]  addr_b;
  logic [255:0] wdata_b;
  logic         ack_b;
  logic [255:0] rdata_b;
  logic         busy_b;

  int n_vec = 0;
  int n_err = 0;

  logic [255:0] model_mem [DEPTH];
  bit           written   [DEPTH];
  int           wq[$];
  logic [255:0] model_rd;

  always #5 clk = ~clk;

  dmem_line_responder #(.LATENCY(LAT), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_dut (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(en), .mem_write_i(we),
    .mem_addr_i(addr), .mem_data_i(wdata), .mem_ack_o(ack),
    .mem_data_o(rdata), .busy_o(busy)
  );

  dmem_line_responder #(.LATENCY(LAT_B), .DEPTH(DEPTH_B), .IDX_W(IDX_W_B)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(en_b), .mem_write_i(we_b),
    .mem_addr_i(addr_b), .mem_data_i(wdata_b), .mem_ack_o(ack_b),
    .mem_data_o(rdata_b), .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] mk_addr(input int idx);
    logic [31:0] a;
    logic [31:0] iv;
    a  = $urandom;
    iv = idx;
    a[IDX_W+4:5] = iv[IDX_W-1:0];
    return a;
  endfunction

  // One complete request on the LATENCY=10 instance; enable held until ack.
  task automatic do_req(input bit w, input logic [31:0] a, input logic [255:0] d,
                        input bit scramble, input string tag);
    int lat;
    bit got;
    bit busy_ok;
    int idx;
    idx = int'(a[IDX_W+4:5]);
    en = 1'b1; we = w; addr = a; wdata = d;
    tick();
    lat = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && lat < LAT + 4) begin
      if (!busy) busy_ok = 1'b0;
      if (scramble) begin
        we = 1'($urandom); addr = $urandom; wdata = rand_line();
      end
      tick();
      lat++;
      if (ack) got = 1'b1;
    end
    en = 1'b0; we = 1'b0;
    check({tag, "_latency"}, 256'(lat), 256'(LAT));
    check({tag, "_busy_wait"}, 256'(busy_ok), 256'd1);
    check({tag, "_busy_ack"}, 256'(busy), 256'd1);
    if (w) begin
      model_mem[idx] = d;
      if (!written[idx]) wq.push_back(idx);
      written[idx] = 1'b1;
    end else begin
      model_rd = model_mem[idx];
    end
    check({tag, "_data"}, rdata, model_rd);
    tick();
    check({tag, "_ack_drop"}, 256'(ack), 256'd0);
    check({tag, "_idle"}, 256'(busy), 256'd0);
  endtask

  initial begin
    logic [255:0] pat;
    logic [255:0] z;
    bit           seen_ack;
    int           n;

    rst = 1'b1;
    en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    en_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    model_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      written[i]   = 1'b0;
    end

    // Reset state
    tick(); tick();
    check("rst_ack", 256'(ack), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_data", rdata, 256'd0);
    check("rst_b_ack", 256'(ack_b), 256'd0);
    check("rst_b_busy", 256'(busy_b), 256'd0);
    rst = 1'b0;
    tick();

    // Known contents on line 3, then an aborted overwrite
    pat = rand_line();
    do_req(1'b1, 32'h0000_0060, pat, 1'b0, "prewrite");

    en = 1'b1; we = 1'b1; addr = 32'h0000_0060; wdata = {32{8'hAA}};
    tick();
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    #2;
    check("abort_ack", 256'(ack), 256'd0);
    check("abort_busy", 256'(busy), 256'd0);
    check("abort_data", rdata, 256'd0);
    model_rd = '0;
    en = 1'b0; we = 1'b0;
    tick(); tick();
    rst = 1'b0;
    seen_ack = 1'b0;
    for (int k = 0; k < LAT + 4; k++) begin
      tick();
      if (ack) seen_ack = 1'b1;
    end
    check("abort_no_ack", 256'(seen_ack), 256'd0);
    do_req(1'b0, 32'h0000_007F, '0, 1'b0, "abort_read");

    // Write then read with offset bits set
    do_req(1'b1, 32'h0000_0060, 256'h1234, 1'b0, "wr1234");
    do_req(1'b0, 32'h0000_007F, '0, 1'b0, "rd1234");

    // Upper address bits wrap onto the same line
    do_req(1'b1, 32'h0000_4060, rand_line(), 1'b0, "alias_wr");
    do_req(1'b0, 32'h0000_0060, '0, 1'b0, "alias_rd");

    // Inputs churned during WAIT are ignored
    do_req(1'b1, mk_addr(7), rand_line(), 1'b1, "scr_wr");
    do_req(1'b0, mk_addr(7), '0, 1'b1, "scr_rd");

    // Enable held across the ack: second request starts right after ACK
    z = rand_line();
    en = 1'b1; we = 1'b1; addr = mk_addr(20); wdata = z;
    tick();
    n = 0;
    while (!ack && n < LAT + 4) begin
      tick();
      n++;
    end
    check("held_first_lat", 256'(n), 256'(LAT));
    model_mem[20] = z;
    if (!written[20]) wq.push_back(20);
    written[20] = 1'b1;
    we = 1'b0; addr = mk_addr(20); wdata = rand_line();
    n = 0;
    tick();
    n++;
    while (!ack && n < 2 * LAT + 6) begin
      tick();
      n++;
    end
    en = 1'b0;
    check("held_second_gap", 256'(n), 256'(LAT + 2));
    model_rd = z;
    check("held_second_data", rdata, model_rd);
    tick();
    tick();
    check("held_idle", 256'(busy), 256'd0);

    // Randomized traffic against the reference array
    for (int t = 0; t < 40; t++) begin
      if (wq.size() == 0 || $urandom_range(0, 1) == 0) begin
        do_req(1'b1, mk_addr(int'($urandom_range(0, DEPTH - 1))), rand_line(),
               1'($urandom), "rnd_wr");
      end else begin
        do_req(1'b0, mk_addr(wq[$urandom_range(0, wq.size() - 1)]), '0,
               1'($urandom), "rnd_rd");
      end
    end

    // LATENCY=1, DEPTH=16 instance: ack one edge after acceptance, busy for 2 cycles
    pat = rand_line();
    for (int k = 0; k < 2; k++) begin
      en_b = 1'b1;
      we_b = (k == 0);
      addr_b = (k == 0) ? 32'h0000_0225 : 32'h0000_0020;
      wdata_b = pat;
      tick();
      en_b = 1'b0;
      check("lat1_accept_ack", 256'(ack_b), 256'd0);
      check("lat1_accept_busy", 256'(busy_b), 256'd1);
      tick();
      check("lat1_ack", 256'(ack_b), 256'd1);
      check("lat1_ack_busy", 256'(busy_b), 256'd1);
      check("lat1_data", rdata_b, (k == 0) ? 256'd0 : pat);
      tick();
      check("lat1_ack_drop", 256'(ack_b), 256'd0);
      check("lat1_idle", 256'(busy_b), 256'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
